ysyx_23060191_lsu: RTL and testbench
====================================

# ysyx_23060191_lsu

Load/store unit directly downstream of the execute stage. Consumes the EXU result (`o_exu_res`) as either a memory address or a pass-through value, together with rs2 store data. Performs one request/acknowledge memory transaction per load/store, with byte-lane masking and load sign/zero extension. Presents a registered result to the write-back stage under a valid/ready handshake.

## Interface
- `CPU_WIDTH`, 32, datapath width; only 32 is supported.
- `LSU_OPT_WIDTH`, 4, width of the LSU op code.

Ports:
- `i_clk  in  1`  sole clock; all state updates on its rising edge.
- `i_rst  in  1`  synchronous, active-high reset.
- `i_valid  in  1`  EXU has an op for the LSU.
- `o_ready  out  1`  LSU can accept; high only in IDLE.
- `i_exu_res  in  32`  EXU result: address for loads/stores, pass-through value otherwise.
- `i_data_Rs2  in  32`  store data.
- `i_lsu_opt  in  4`  op code: 0 NONE, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 SB, 7 SH, 8 SW; codes 9–15 are treated as NONE.
- `o_mem_req  out  1`  memory request.
- `o_mem_we  out  1`  request is a write.
- `o_mem_addr  out  32`  word-aligned address `{addr[31:2],2'b00}`.
- `o_mem_wdata  out  32`  lane-replicated store data.
- `o_mem_wmask  out  4`  byte-lane write enables; 0 for loads.
- `i_mem_ack  in  1`  memory completes the request; read data is valid in the same cycle.
- `i_mem_rdata  in  32`  read word.
- `o_valid  out  1`  result available to WBU.
- `i_wbu_ready  in  1`  WBU consumes the result.
- `o_lsu_res  out  32`  extended load data, or captured `i_exu_res`.
- `o_misalign  out  1`  the op was a misaligned access; accompanies `o_valid`.

## Operation
- FSM with three states: IDLE, REQ, DONE.
- **IDLE**
  - `o_ready=1`.
  - On `i_valid`: capture addr, rs2 and opt.
  - NONE → DONE with `o_lsu_res=i_exu_res`.
  - Misaligned access (halfword with `addr[0]=1`; word with `addr[1:0]≠0`) → DONE with `o_misalign=1`, `o_lsu_res=addr`, and no memory request.
  - Aligned load/store → REQ.
- **REQ**
  - Hold `o_mem_req=1` and all `o_mem_*` outputs stable until `i_mem_ack`.
  - On ack → DONE. For loads, register the extracted value: `lane = i_mem_rdata >> (8*addr[1:0])`.
    - LB: sign-extend `lane[7:0]`.
    - LBU: zero-extend `lane[7:0]`.
    - LH: sign-extend `lane[15:0]`.
    - LHU: zero-extend `lane[15:0]`.
    - LW: the full word.
  - For stores, `o_lsu_res=0`.
- **DONE**
  - `o_valid=1`; outputs stay stable until `i_wbu_ready`, then → IDLE.
  - `o_ready=0`, so there is no accept in the same cycle as hand-off.
- **Store lanes**
  - SB: mask `4'b0001<<addr[1:0]`, wdata `{4{rs2[7:0]}}`.
  - SH: mask `4'b0011<<addr[1:0]`, wdata `{2{rs2[15:0]}}`.
  - SW: mask `4'hF`, wdata `rs2`.
- `o_mem_we=1` only for SB/SH/SW. Outside REQ, `o_mem_req=0`; the other `o_mem_*` outputs are don't-care but deterministic (driven from captured state).

## Timing
- **Reset values**: state IDLE, `o_ready=1`, `o_valid=0`, `o_mem_req=0`, `o_mem_we=0`, `o_mem_wmask=0`, `o_lsu_res=0`, `o_misalign=0`.
- **NONE or misaligned**: accept at edge N; `o_valid` high from cycle N+1.
- **Memory op**: accept at edge N; `o_mem_req` high from cycle N+1. If the ack arrives in cycle N+k (k≥1), `o_valid` is high from cycle N+k+1.
- **Minimum throughput**: one op per 2 cycles for NONE; one per 3 cycles for memory ops with zero-wait ack.
- `i_mem_ack` is ignored outside REQ; a stray or late ack has no effect.
- `i_valid` is ignored outside IDLE; EXU must hold its op until `o_ready` is seen.
- **Reset mid-transaction**:
  - State returns to IDLE at the reset edge and `o_mem_req` drops in the following cycle.
  - Any captured result is discarded.
  - An ack arriving afterwards is ignored.
- **Simultaneous ack and reset**: reset wins; no DONE entry.
- **WBU backpressure**: `o_valid`, `o_lsu_res` and `o_misalign` hold unchanged for any number of cycles with `i_wbu_ready=0`.

## Test plan
- **NONE pass-through**: `i_exu_res=0x12345678`, opt=0 → `o_valid` one cycle later with `o_lsu_res=0x12345678` and no `o_mem_req`.
- **LB/LBU sign handling**: addr `0x80000003`, rdata `0x80FF7F01`:
  - LB → `0xFFFFFF80`.
  - LBU → `0x00000080`.
  - At addr `...01`, LB → `0x0000007F`.
- **SH upper half**: addr `0x80000002`, rs2 `0xAAAA1234` → wmask `4'b1100`, wdata `0x12341234`, `o_mem_addr=0x80000000`, `o_mem_we=1`.
- **Misaligned LW**: addr `0x80000006` → no request; `o_misalign=1`; `o_lsu_res=0x80000006`.
- **Wait states and backpressure**: LW with ack after 5 cycles, rdata `0xDEADBEEF`:
  - `o_mem_*` stable for all 5 cycles.
  - `i_wbu_ready=0` for 3 cycles after `o_valid` → result stays `0xDEADBEEF` until taken, then `o_ready=1`.
- **Reset in REQ**: assert `i_rst` while waiting for ack, then send an ack 2 cycles later → IDLE, `o_valid` never rises, and the next NONE op completes normally.

Source files
------------

// File: rtl/ysyx_23060191_lsu.sv
// Load/store unit: one request/acknowledge memory transaction per load/store,
// byte-lane store masking, load extension, registered valid/ready result to WBU.
module ysyx_23060191_lsu #(
  parameter int CPU_WIDTH     = 32,
  parameter int LSU_OPT_WIDTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [CPU_WIDTH-1:0]     i_exu_res,
  input  logic [CPU_WIDTH-1:0]     i_data_Rs2,
  input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
  output logic                     o_mem_req,
  output logic                     o_mem_we,
  output logic [CPU_WIDTH-1:0]     o_mem_addr,
  output logic [CPU_WIDTH-1:0]     o_mem_wdata,
  output logic [3:0]               o_mem_wmask,
  input  logic                     i_mem_ack,
  input  logic [CPU_WIDTH-1:0]     i_mem_rdata,
  output logic                     o_valid,
  input  logic                     i_wbu_ready,
  output logic [CPU_WIDTH-1:0]     o_lsu_res,
  output logic                     o_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  typedef enum logic [LSU_OPT_WIDTH-1:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LH   = 4'd2,
    OP_LW   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LHU  = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8
  } op_e;

  state_e               state;
  op_e                  op;
  op_e                  op_q;
  logic [1:0]           off_q;

  logic                 is_mem;
  logic                 is_store;
  logic                 misalign;
  logic [3:0]           st_wmask;
  logic [CPU_WIDTH-1:0] st_wdata;
  logic [CPU_WIDTH-1:0] lane;
  logic [CPU_WIDTH-1:0] ld_data;

  // Decode of the incoming op; codes outside the enum fall to NONE.
  always_comb begin
    op       = op_e'(i_lsu_opt);
    is_mem   = 1'b0;
    is_store = 1'b0;
    misalign = 1'b0;
    st_wmask = '0;
    st_wdata = i_data_Rs2;
    case (op)
      OP_LB, OP_LBU: is_mem = 1'b1;
      OP_LH, OP_LHU: begin
        is_mem   = 1'b1;
        misalign = i_exu_res[0];
      end
      OP_LW: begin
        is_mem   = 1'b1;
        misalign = |i_exu_res[1:0];
      end
      OP_SB: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        st_wmask = 4'b0001 << i_exu_res[1:0];
        st_wdata = {4{i_data_Rs2[7:0]}};
      end
      OP_SH: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        misalign = i_exu_res[0];
        st_wmask = 4'b0011 << i_exu_res[1:0];
        st_wdata = {2{i_data_Rs2[15:0]}};
      end
      OP_SW: begin
        is_mem   = 1'b1;
        is_store = 1'b1;
        misalign = |i_exu_res[1:0];
        st_wmask = 4'hF;
      end
      default: ;
    endcase
  end

  // Load extraction from the captured op and byte offset; stores yield zero.
  always_comb begin
    lane    = i_mem_rdata >> {off_q, 3'b000};
    ld_data = '0;
    case (op_q)
      OP_LB:   ld_data = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  ld_data = {24'h0, lane[7:0]};
      OP_LH:   ld_data = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  ld_data = {16'h0, lane[15:0]};
      OP_LW:   ld_data = i_mem_rdata;
      default: ld_data = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      op_q        <= OP_NONE;
      off_q       <= '0;
      o_ready     <= 1'b1;
      o_valid     <= 1'b0;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_wmask <= '0;
      o_lsu_res   <= '0;
      o_misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op_q        <= op;
            off_q       <= i_exu_res[1:0];
            o_ready     <= 1'b0;
            o_mem_addr  <= {i_exu_res[CPU_WIDTH-1:2], 2'b00};
            o_mem_wdata <= st_wdata;
            o_mem_we    <= is_store & ~misalign;
            o_mem_wmask <= (is_store & ~misalign) ? st_wmask : 4'b0000;
            if (is_mem && !misalign) begin
              state     <= REQ;
              o_mem_req <= 1'b1;
            end else begin
              // NONE and misaligned both report the raw EXU value.
              state      <= DONE;
              o_valid    <= 1'b1;
              o_misalign <= misalign;
              o_lsu_res  <= i_exu_res;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            state      <= DONE;
            o_mem_req  <= 1'b0;
            o_valid    <= 1'b1;
            o_misalign <= 1'b0;
            o_lsu_res  <= ld_data;
          end
        end
        DONE: begin
          if (i_wbu_ready) begin
            state      <= IDLE;
            o_valid    <= 1'b0;
            o_ready    <= 1'b1;
            o_misalign <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060191_lsu.sv
// Scoreboard bench for ysyx_23060191_lsu: directed ops push expected results,
// a negedge monitor pops and compares on every WBU hand-off.
module tb_ysyx_23060191_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_exu_res;
  logic [31:0] i_data_Rs2;
  logic [3:0]  i_lsu_opt;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_valid;
  logic        i_wbu_ready;
  logic [31:0] o_lsu_res;
  logic        o_misalign;

  ysyx_23060191_lsu #(.CPU_WIDTH(32), .LSU_OPT_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_exu_res(i_exu_res), .i_data_Rs2(i_data_Rs2), .i_lsu_opt(i_lsu_opt),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_valid(o_valid), .i_wbu_ready(i_wbu_ready),
    .o_lsu_res(o_lsu_res), .o_misalign(o_misalign)
  );

  always #5 i_clk = ~i_clk;

  int passed = 0;
  int total  = 0;
  logic [32:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Monitor: compare on each hand-off, and verify results hold under backpressure.
  logic        held = 1'b0;
  logic [32:0] held_val;
  always @(negedge i_clk) begin
    logic [32:0] e;
    if (i_rst) begin
      held = 1'b0;
    end else if (o_valid) begin
      if (held) chk("bp_hold", {31'h0, o_misalign, o_lsu_res} >> 0, {31'h0, held_val} >> 0);
      if (i_wbu_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'h0, o_valid}, 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("lsu_res", o_lsu_res, e[31:0]);
          chk("misalign", {31'h0, o_misalign}, {31'h0, e[32]});
        end
      end else begin
        held     = 1'b1;
        held_val = {o_misalign, o_lsu_res};
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called just after a rising edge while the DUT is idle.
  task automatic do_op(input logic [3:0] opt, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] rdata, input int k, input int bp,
                       input logic exp_req, input logic exp_we, input logic [3:0] exp_mask,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                       input logic exp_mis);
    i_valid    = 1'b1;
    i_lsu_opt  = opt;
    i_exu_res  = addr;
    i_data_Rs2 = rs2;
    exp_q.push_back({exp_mis, exp_res});
    @(negedge i_clk);
    chk("ready_idle", {31'h0, o_ready}, 32'h1);
    tick();
    i_valid    = 1'b0;
    i_exu_res  = ~addr;
    i_data_Rs2 = ~rs2;
    i_lsu_opt  = 4'd0;
    if (exp_req) begin
      for (int i = 1; i <= k; i++) begin
        i_mem_ack   = (i == k);
        i_mem_rdata = (i == k) ? rdata : 32'h5A5A5A5A;
        @(negedge i_clk);
        chk("mem_req", {31'h0, o_mem_req}, 32'h1);
        chk("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
        chk("mem_we", {31'h0, o_mem_we}, {31'h0, exp_we});
        chk("mem_wmask", {28'h0, o_mem_wmask}, {28'h0, exp_mask});
        if (exp_we) chk("mem_wdata", o_mem_wdata, exp_wdata);
        chk("valid_wait", {31'h0, o_valid}, 32'h0);
        tick();
      end
      i_mem_ack   = 1'b0;
      i_mem_rdata = 32'h0;
    end
    i_wbu_ready = (bp == 0);
    @(negedge i_clk);
    chk("no_req_done", {31'h0, o_mem_req}, 32'h0);
    chk("valid_done", {31'h0, o_valid}, 32'h1);
    chk("ready_done", {31'h0, o_ready}, 32'h0);
    for (int j = 1; j <= bp; j++) begin
      tick();
      if (j == bp) i_wbu_ready = 1'b1;
      @(negedge i_clk);
      chk("valid_bp", {31'h0, o_valid}, 32'h1);
    end
    tick();
    @(negedge i_clk);
    chk("ready_after", {31'h0, o_ready}, 32'h1);
    chk("valid_after", {31'h0, o_valid}, 32'h0);
    tick();
  endtask

  initial begin
    int n;
    i_rst = 1'b1; i_valid = 1'b0; i_exu_res = '0; i_data_Rs2 = '0; i_lsu_opt = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0; i_wbu_ready = 1'b1;
    tick(); tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_ready", {31'h0, o_ready}, 32'h1);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_req", {31'h0, o_mem_req}, 32'h0);
    chk("rst_we", {31'h0, o_mem_we}, 32'h0);
    chk("rst_wmask", {28'h0, o_mem_wmask}, 32'h0);
    chk("rst_res", o_lsu_res, 32'h0);
    chk("rst_mis", {31'h0, o_misalign}, 32'h0);
    tick();

    // Stray ack while idle must do nothing.
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    tick();
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    chk("stray_ack_valid", {31'h0, o_valid}, 32'h0);
    tick();

    //     opt    addr          rs2           rdata        k  bp req we  mask     wdata         res           mis
    do_op(4'd0, 32'h12345678, 32'h0,        32'h0,       1, 0, 0, 0, 4'b0000, 32'h0,        32'h12345678, 0);
    do_op(4'd1, 32'h80000003, 32'h0,        32'h80FF7F01, 1, 0, 1, 0, 4'b0000, 32'h0,       32'hFFFFFF80, 0);
    do_op(4'd4, 32'h80000003, 32'h0,        32'h80FF7F01, 1, 0, 1, 0, 4'b0000, 32'h0,       32'h00000080, 0);
    do_op(4'd1, 32'h80000001, 32'h0,        32'h80FF7F01, 1, 0, 1, 0, 4'b0000, 32'h0,       32'h0000007F, 0);
    do_op(4'd2, 32'h80000002, 32'h0,        32'h80FF7F01, 2, 0, 1, 0, 4'b0000, 32'h0,       32'hFFFF80FF, 0);
    do_op(4'd5, 32'h80000000, 32'h0,        32'h80FF7F01, 1, 0, 1, 0, 4'b0000, 32'h0,       32'h00007F01, 0);
    do_op(4'd3, 32'h80000004, 32'h0,        32'h80FF7F01, 1, 0, 1, 0, 4'b0000, 32'h0,       32'h80FF7F01, 0);
    do_op(4'd7, 32'h80000002, 32'hAAAA1234, 32'h0,       2, 0, 1, 1, 4'b1100, 32'h12341234, 32'h0,        0);
    do_op(4'd6, 32'h80000001, 32'h000000A5, 32'hFFFFFFFF, 1, 0, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,       0);
    do_op(4'd8, 32'h80000008, 32'hCAFEF00D, 32'h0,       1, 0, 1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    do_op(4'd3, 32'h80000006, 32'h0,        32'h0,       1, 0, 0, 0, 4'b0000, 32'h0,        32'h80000006, 1);
    do_op(4'd7, 32'h80000003, 32'h11112222, 32'h0,       1, 0, 0, 0, 4'b0000, 32'h0,        32'h80000003, 1);
    do_op(4'd2, 32'h80000001, 32'h0,        32'h0,       1, 0, 0, 0, 4'b0000, 32'h0,        32'h80000001, 1);
    do_op(4'd3, 32'h80000010, 32'h0,        32'hDEADBEEF, 5, 3, 1, 0, 4'b0000, 32'h0,       32'hDEADBEEF, 0);
    do_op(4'd12, 32'hA5A5F00F, 32'h0,       32'h0,       1, 0, 0, 0, 4'b0000, 32'h0,        32'hA5A5F00F, 0);

    // Reset while waiting for ack; a late ack must be ignored.
    i_valid = 1'b1; i_lsu_opt = 4'd3; i_exu_res = 32'h80000020;
    tick();
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("rst_req_pending", {31'h0, o_mem_req}, 32'h1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_req", {31'h0, o_mem_req}, 32'h0);
    chk("rst_mid_ready", {31'h0, o_ready}, 32'h1);
    tick();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h13572468;
    tick();
    i_mem_ack = 1'b0;
    @(negedge i_clk);
    chk("late_ack_valid", {31'h0, o_valid}, 32'h0);
    chk("late_ack_ready", {31'h0, o_ready}, 32'h1);
    tick();

    // Ack and reset in the same cycle: reset wins.
    i_valid = 1'b1; i_lsu_opt = 4'd3; i_exu_res = 32'h80000024;
    tick();
    i_valid = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h24681357; i_rst = 1'b1;
    tick();
    i_mem_ack = 1'b0; i_rst = 1'b0;
    @(negedge i_clk);
    chk("ack_rst_valid", {31'h0, o_valid}, 32'h0);
    chk("ack_rst_req", {31'h0, o_mem_req}, 32'h0);
    tick();

    do_op(4'd0, 32'h0BADF00D, 32'h0, 32'h0, 1, 0, 0, 0, 4'b0000, 32'h0, 32'h0BADF00D, 0);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
